mem_line_requester: RTL

- Initiator-side controller for the word-addressed line RAM: takes cache-line fill requests from an L1 cache, with optional dirty-victim writeback, and sequences them onto the RAM's line-read/line-write interface.
- Models a fixed memory latency per access and returns the filled 128-bit line to the cache through a valid/ready handshake.
- Sits between the cache miss path and the RAM.

---
 rtl/mem_if_pkg.sv | 24 ++
 rtl/mem_lat_timer.sv | 40 ++++
 rtl/mem_line_requester.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and constants for the cache-line requester and its RAM interface.
// A line is four 32-bit words, with word 0 in the least significant bits.
package mem_if_pkg;

  localparam int LINE_ADDR_W    = 26;
  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    RESP
  } req_state_t;

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] fill_addr;
    logic                   wb;
    logic [LINE_ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0]      wb_data;
  } line_req_t;

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that measures one RAM access of LATENCY cycles.
// A start pulse loads LATENCY-1; done is high in the final cycle (count 0).
module mem_lat_timer #(
  parameter  int LATENCY = 5,
  localparam int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done,
  output logic almost_done
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every path assigns cnt_d, starting from a default, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: registers update with <= so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done        = (cnt_q == '0);
  assign almost_done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_line_requester.sv
// Sequences L1 miss requests (optional dirty-victim writeback, then line fill)
// onto the line RAM, and returns the filled line over a valid/ready handshake.
module mem_line_requester
  import mem_if_pkg::*;
#(
  parameter int MEM_LATENCY = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [LINE_ADDR_W-1:0] req_fill_addr,
  input  logic                   req_wb,
  input  logic [LINE_ADDR_W-1:0] req_wb_addr,
  input  logic [LINE_W-1:0]      req_wb_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [LINE_ADDR_W-1:0] resp_addr,
  output logic [LINE_W-1:0]      resp_data,
  output logic [LINE_ADDR_W-1:0] mem_rd_addr,
  input  logic [LINE_W-1:0]      mem_rd_data,
  output logic [LINE_ADDR_W-1:0] mem_wr_addr,
  output logic [LINE_W-1:0]      mem_wr_data,
  output logic                   mem_wr_en
);

  req_state_t state_q, state_d;

  logic                   resp_valid_q, resp_valid_d;
  logic [LINE_ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic [LINE_W-1:0]      resp_data_q, resp_data_d;
  logic [LINE_ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic [LINE_ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [LINE_W-1:0]      mem_wr_data_q, mem_wr_data_d;
  logic                   mem_wr_en_q, mem_wr_en_d;

  line_req_t req_in;
  logic      accept;
  logic      tmr_start, tmr_done, tmr_almost_done;

  assign req_in = '{fill_addr: req_fill_addr, wb: req_wb,
                    wb_addr: req_wb_addr, wb_data: req_wb_data};

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // One timer serves both phases: restarted on accept and on the WB->FILL hop.
  assign tmr_start = accept || ((state_q == WB) && tmr_done);

  mem_lat_timer #(
    .LATENCY (MEM_LATENCY)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .start       (tmr_start),
    .done        (tmr_done),
    .almost_done (tmr_almost_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      resp_valid_q  <= 1'b0;
      resp_addr_q   <= '0;
      resp_data_q   <= '0;
      mem_rd_addr_q <= '0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_valid_q  <= resp_valid_d;
      resp_addr_q   <= resp_addr_d;
      resp_data_q   <= resp_data_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_in.wb ? WB : FILL;
      WB:      if (tmr_done) state_d = FILL;
      FILL:    if (tmr_done) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The write enable is registered, so it is raised one cycle ahead of the
  // final WB cycle; a reset in that cycle clears it before it can pulse.
  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_addr_d   = resp_addr_q;
    resp_data_d   = resp_data_q;
    mem_rd_addr_d = mem_rd_addr_q;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_en_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mem_rd_addr_d = req_in.fill_addr;
          if (req_in.wb) begin
            mem_wr_addr_d = req_in.wb_addr;
            mem_wr_data_d = req_in.wb_data;
            mem_wr_en_d   = (MEM_LATENCY == 1);
          end
        end
      end
      WB:   mem_wr_en_d = tmr_almost_done;
      FILL: begin
        if (tmr_done) begin
          resp_data_d  = mem_rd_data;
          resp_addr_d  = mem_rd_addr_q;
          resp_valid_d = 1'b1;
        end
      end
      RESP: if (resp_ready) resp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign resp_valid  = resp_valid_q;
  assign resp_addr   = resp_addr_q;
  assign resp_data   = resp_data_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_en   = mem_wr_en_q;

endmodule
